blrowseq: RTL and testbench
===========================

Name: blrowseq

Overview:
- Global-shutter frame and row readout sequencer for the 10-tap image sensor.
- Per frame it generates the reset, integration and transfer pulses (PG/LRST, INT, TX), then sequences each row: address, row start, load-shift, data-read window.
- Sits between the sync generator (tv/th, exposure) and the sensor control pads. The top level registers its outputs onto A, ROW_STRT_IN, LD_SHIFT_IN, DATA_READ_IN, PG_IN, TX_IN and LRST_IN.

Parameters:
- AW, 10: row address width.
- NROWS, 1024: rows read per frame, 1..2^AW.
- NCOL_RD, 128: enrd cycles per row (1280 px / 10 taps).
- T_RSTRT, 2: rstrt pulse length, in clk cycles.
- T_LDSH, 4: ldshft pulse length, in clk cycles.
- T_PG, 16: ipg/lrst pulse length, in clk cycles.
- T_TX, 8: itx pulse length, in clk cycles.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- init_n, in, 1: synchronous reset, active-low.
- en, in, 1: detector enabled (endet); low aborts the sequence.
- tv, in, 1: frame-start pulse, one clk wide.
- th, in, 1: line pulse, one clk wide.
- iexp, in, 11: exposure in th periods; 0 is treated as 1.
- arow, out, AW: row address.
- rstrt, out, 1: row start.
- ldshft, out, 1: load shift register.
- enrd, out, 1: data read window.
- ipg, out, 1: pixel global reset.
- lrst, out, 1: line reset; identical timing to ipg.
- itx, out, 1: charge transfer.
- oint, out, 1: integration active.
- busy, out, 1: frame sequence in progress.
- ovr, out, 1: one-cycle pulse when tv or th is dropped.

Behaviour:
- Reset: all outputs are registered and 0 while init_n=0 at a rising edge, including arow=0. Both FSMs go to idle and all counters clear.
- Output timing: outputs are a registered decode of state, so a pulse appears one cycle after its state is entered.
- Frame FSM:
  - F_IDLE: on tv & en go to F_PG. tv at edge n gives ipg=lrst=1 from edge n+1.
  - F_PG: ipg=lrst=1 for exactly T_PG cycles, then F_INT.
  - F_INT: oint=1. Count th pulses; when count reaches max(iexp,1), go to F_TX on the next cycle. iexp is sampled once on F_PG entry; later changes apply to the next frame.
  - F_TX: itx=1 for exactly T_TX cycles, then F_READ with row=0.
  - F_READ: runs the row FSM. After row NROWS-1 completes its read window, return to F_IDLE.
  - busy=1 in every state except F_IDLE.
- Row FSM (active only in F_READ):
  - R_WAIT: arow=row; on th go to R_STRT.
  - R_STRT: rstrt=1 for T_RSTRT cycles.
  - R_LDSH: ldshft=1 for T_LDSH cycles.
  - R_RD: enrd=1 for NCOL_RD cycles, then row++ and back to R_WAIT.
  - arow is stable from R_WAIT through R_RD and updates only on R_RD exit.
  - The three pulses never overlap. There are no gap cycles between phases.
- Simultaneous and dropped events:
  - th in the same cycle as the F_TX→F_READ transition is not used; the first row waits for the next th.
  - th while the row FSM is not in R_WAIT is ignored and pulses ovr.
  - tv while busy is ignored and pulses ovr; the sequence continues.
  - th and tv in the same cycle in F_IDLE: tv wins and th is not counted.
- Abort: en=0 in any state → next cycle all pulses 0, arow=0, F_IDLE. A tv coincident with the en drop is ignored.
- Widths:
  - Row counter is AW bits; it wraps only via the NROWS compare, never by overflow.
  - th counter is 11 bits and compares for equality against max(iexp,1).
  - Phase counter is wide enough for max(NCOL_RD, T_PG, T_TX) and reloads on every state entry.

Decomposition:
- Shared package blcam_pkg holds:
  - frame state enum: F_IDLE, F_PG, F_INT, F_TX, F_READ.
  - row state enum: R_WAIT, R_STRT, R_LDSH, R_RD.
  - default timing constants.
- One sub-module, blrowphase: the row FSM plus phase counter. Interface: start, row, done, rstrt, ldshft, enrd, ovr_th.
- blrowseq contains the frame FSM, exposure counter and output registers.

Test Plan (NROWS=4, NCOL_RD=8, T_RSTRT=2, T_LDSH=3, T_PG=4, T_TX=2):
- Normal frame:
  - Stimulus: en=1, iexp=3, tv at cycle 10, th every 20 cycles.
  - Response: ipg=lrst=1 cycles 11-14; oint high until the 3rd th plus 1; itx=1 for 2 cycles.
  - Then 4 rows, each showing rstrt 2 / ldshft 3 / enrd 8 consecutive cycles with arow=0,1,2,3.
  - busy falls after row 3 enrd ends; ovr never pulses.
- iexp=0: oint spans exactly 1 th.
- iexp changed mid-integration: the frame uses the value latched at F_PG entry.
- Overrun: tv during F_READ → ovr=1 for 1 cycle and the frame is unchanged. th during R_RD → ovr=1 and that row count is unaffected.
- Abort: en=0 during R_LDSH of row 2 → next cycle ldshft=0, arow=0, busy=0. A later tv starts a full frame from row 0.
- Reset: init_n=0 for 1 cycle mid-F_INT → all outputs 0 next cycle; tv is required to restart.

Source files
------------

// File: rtl/blcam_pkg.sv
// Shared state encodings and default timing for the camera sequencer blocks.
package blcam_pkg;

  typedef enum logic [2:0] {
    F_IDLE,
    F_PG,
    F_INT,
    F_TX,
    F_READ
  } frame_state_t;

  typedef enum logic [1:0] {
    R_WAIT,
    R_STRT,
    R_LDSH,
    R_RD
  } row_state_t;

  localparam int unsigned DEF_AW      = 10;
  localparam int unsigned DEF_NROWS   = 1024;
  localparam int unsigned DEF_NCOL_RD = 128;
  localparam int unsigned DEF_T_RSTRT = 2;
  localparam int unsigned DEF_T_LDSH  = 4;
  localparam int unsigned DEF_T_PG    = 16;
  localparam int unsigned DEF_T_TX    = 8;
  localparam int unsigned EXPW        = 11;

  // Larger of two timing constants, used to size phase counters.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/blrowphase.sv
// Row readout FSM: waits for th, then rstrt / ldshft / enrd phases and row advance.
module blrowphase
  import blcam_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned NROWS   = DEF_NROWS,
  parameter int unsigned NCOL_RD = DEF_NCOL_RD,
  parameter int unsigned T_RSTRT = DEF_T_RSTRT,
  parameter int unsigned T_LDSH  = DEF_T_LDSH
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          start_i,   // high while the frame is reading; low parks at row 0
  input  logic          th_i,
  output logic [AW-1:0] row_o,
  output logic          done_c,
  output logic          rstrt_c,
  output logic          ldshft_c,
  output logic          enrd_c,
  output logic          ovr_th_c
);

  localparam int unsigned CMAX = max2(NCOL_RD, max2(T_RSTRT, T_LDSH));
  localparam int unsigned CW   = $clog2(CMAX + 1);

  row_state_t    st_q, st_d;
  logic [AW-1:0] row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: phase counter reloads on every entry, row advances on read exit.
  always_comb begin
    st_d     = st_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    done_c   = 1'b0;
    if (!start_i) begin
      st_d  = R_WAIT;
      row_d = '0;
      cnt_d = '0;
    end else begin
      case (st_q)
        R_WAIT: begin
          if (th_i) begin
            st_d  = R_STRT;
            cnt_d = CW'(T_RSTRT - 1);
          end
        end
        R_STRT: begin
          if (cnt_q == '0) begin
            st_d  = R_LDSH;
            cnt_d = CW'(T_LDSH - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        R_LDSH: begin
          if (cnt_q == '0) begin
            st_d  = R_RD;
            cnt_d = CW'(NCOL_RD - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        R_RD: begin
          if (cnt_q == '0) begin
            st_d  = R_WAIT;
            cnt_d = '0;
            if (row_q == AW'(NROWS - 1)) begin
              row_d  = '0;
              done_c = 1'b1;
            end else begin
              row_d = row_q + AW'(1);
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: st_d = R_WAIT;
      endcase
    end
  end

  // Phase decodes, gated so an abort clears them before the state catches up.
  always_comb begin
    rstrt_c  = start_i && (st_q == R_STRT);
    ldshft_c = start_i && (st_q == R_LDSH);
    enrd_c   = start_i && (st_q == R_RD);
    ovr_th_c = start_i && th_i && (st_q != R_WAIT);
    row_o    = start_i ? row_q : '0;
  end

  // State, row and phase registers.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      st_q  <= R_WAIT;
      row_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/blrowseq.sv
// Frame sequencer: global reset, integration, transfer, then row readout; outputs registered.
module blrowseq
  import blcam_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned NROWS   = DEF_NROWS,
  parameter int unsigned NCOL_RD = DEF_NCOL_RD,
  parameter int unsigned T_RSTRT = DEF_T_RSTRT,
  parameter int unsigned T_LDSH  = DEF_T_LDSH,
  parameter int unsigned T_PG    = DEF_T_PG,
  parameter int unsigned T_TX    = DEF_T_TX
) (
  input  logic            clk,
  input  logic            init_n,
  input  logic            en,
  input  logic            tv,
  input  logic            th,
  input  logic [EXPW-1:0] iexp,
  output logic [AW-1:0]   arow,
  output logic            rstrt,
  output logic            ldshft,
  output logic            enrd,
  output logic            ipg,
  output logic            lrst,
  output logic            itx,
  output logic            oint,
  output logic            busy,
  output logic            ovr
);

  localparam int unsigned FCW = $clog2(max2(T_PG, T_TX) + 1);

  frame_state_t    fst_q, fst_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [EXPW-1:0] thcnt_q, thcnt_d;
  logic [EXPW-1:0] exp_q, exp_d;

  logic [AW-1:0] arow_q, arow_d;
  logic rstrt_q, ldshft_q, enrd_q, pg_q, itx_q, oint_q, busy_q, ovr_q;
  logic rstrt_d, ldshft_d, enrd_d, pg_d, itx_d, oint_d, busy_d, ovr_d;

  logic          row_start;
  logic [AW-1:0] row_num;
  logic          row_done_c, row_rstrt_c, row_ldshft_c, row_enrd_c, row_ovr_th_c;

  assign row_start = en && (fst_q == F_READ);

  blrowphase #(
    .AW      (AW),
    .NROWS   (NROWS),
    .NCOL_RD (NCOL_RD),
    .T_RSTRT (T_RSTRT),
    .T_LDSH  (T_LDSH)
  ) u_rowphase (
    .clk      (clk),
    .init_n   (init_n),
    .start_i  (row_start),
    .th_i     (th),
    .row_o    (row_num),
    .done_c   (row_done_c),
    .rstrt_c  (row_rstrt_c),
    .ldshft_c (row_ldshft_c),
    .enrd_c   (row_enrd_c),
    .ovr_th_c (row_ovr_th_c)
  );

  // Frame next-state, exposure latch and th counting.
  always_comb begin
    fst_d   = fst_q;
    fcnt_d  = fcnt_q;
    thcnt_d = thcnt_q;
    exp_d   = exp_q;
    if (!en) begin
      fst_d   = F_IDLE;
      fcnt_d  = '0;
      thcnt_d = '0;
    end else begin
      case (fst_q)
        F_IDLE: begin
          if (tv) begin
            fst_d   = F_PG;
            fcnt_d  = FCW'(T_PG - 1);
            thcnt_d = '0;
            exp_d   = (iexp == '0) ? EXPW'(1) : iexp;
          end
        end
        F_PG: begin
          if (fcnt_q == '0) fst_d = F_INT;
          else              fcnt_d = fcnt_q - FCW'(1);
        end
        F_INT: begin
          if (thcnt_q == exp_q) begin
            fst_d  = F_TX;
            fcnt_d = FCW'(T_TX - 1);
          end else if (th) begin
            thcnt_d = thcnt_q + EXPW'(1);
          end
        end
        F_TX: begin
          if (fcnt_q == '0) begin
            fst_d  = F_READ;
            fcnt_d = '0;
          end else begin
            fcnt_d = fcnt_q - FCW'(1);
          end
        end
        F_READ: begin
          if (row_done_c) fst_d = F_IDLE;
        end
        default: fst_d = F_IDLE;
      endcase
    end
  end

  // Output decode of the current state; en low forces everything quiet.
  always_comb begin
    pg_d     = en && (fst_q == F_PG);
    oint_d   = en && (fst_q == F_INT);
    itx_d    = en && (fst_q == F_TX);
    busy_d   = en && (fst_q != F_IDLE);
    rstrt_d  = row_rstrt_c;
    ldshft_d = row_ldshft_c;
    enrd_d   = row_enrd_c;
    arow_d   = row_num;
    ovr_d    = row_ovr_th_c || (en && tv && (fst_q != F_IDLE));
  end

  // Frame state and output registers.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      fst_q    <= F_IDLE;
      fcnt_q   <= '0;
      thcnt_q  <= '0;
      exp_q    <= '0;
      arow_q   <= '0;
      rstrt_q  <= 1'b0;
      ldshft_q <= 1'b0;
      enrd_q   <= 1'b0;
      pg_q     <= 1'b0;
      itx_q    <= 1'b0;
      oint_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      fst_q    <= fst_d;
      fcnt_q   <= fcnt_d;
      thcnt_q  <= thcnt_d;
      exp_q    <= exp_d;
      arow_q   <= arow_d;
      rstrt_q  <= rstrt_d;
      ldshft_q <= ldshft_d;
      enrd_q   <= enrd_d;
      pg_q     <= pg_d;
      itx_q    <= itx_d;
      oint_q   <= oint_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign arow   = arow_q;
  assign rstrt  = rstrt_q;
  assign ldshft = ldshft_q;
  assign enrd   = enrd_q;
  assign ipg    = pg_q;
  assign lrst   = pg_q;
  assign itx    = itx_q;
  assign oint   = oint_q;
  assign busy   = busy_q;
  assign ovr    = ovr_q;

endmodule

// File: tb/tb_blrowseq.sv
// Directed bench for blrowseq with NROWS=4, NCOL_RD=8, T_RSTRT=2, T_LDSH=3, T_PG=4, T_TX=2.
module tb_blrowseq;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        en = 1'b0;
  logic        tv = 1'b0;
  logic        th = 1'b0;
  logic [10:0] iexp = '0;
  logic [1:0]  arow;
  logic        rstrt, ldshft, enrd, ipg, lrst, itx, oint, busy, ovr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  blrowseq #(
    .AW(2), .NROWS(4), .NCOL_RD(8), .T_RSTRT(2), .T_LDSH(3), .T_PG(4), .T_TX(2)
  ) dut (
    .clk(clk), .init_n(init_n), .en(en), .tv(tv), .th(th), .iexp(iexp),
    .arow(arow), .rstrt(rstrt), .ldshft(ldshft), .enrd(enrd), .ipg(ipg),
    .lrst(lrst), .itx(itx), .oint(oint), .busy(busy), .ovr(ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive inputs across one rising edge, return at the next negedge.
  task automatic step(input logic tv_v, input logic th_v);
    tv = tv_v;
    th = th_v;
    @(negedge clk);
    tv = 1'b0;
    th = 1'b0;
  endtask

  function automatic logic [31:0] all_out();
    return 32'({arow, rstrt, ldshft, enrd, ipg, lrst, itx, oint, busy, ovr});
  endfunction

  // tv, PG pulse, integration over nth th pulses, TX pulse; ends with rows waiting at row 0.
  task automatic frame_head(input logic [10:0] exp_v, input logic [10:0] exp_late,
                            input int nth, input logic th_with_tv);
    iexp = exp_v;
    step(1'b1, th_with_tv);
    chk("ipg_lag", 32'(ipg), 32'(0));
    chk("busy_lag", 32'(busy), 32'(0));
    chk("ovr_idle_tv", 32'(ovr), 32'(0));
    iexp = exp_late;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0);
      chk("ipg_on", 32'(ipg), 32'(1));
      chk("lrst_on", 32'(lrst), 32'(1));
      chk("pg_busy", 32'(busy), 32'(1));
      chk("pg_oint", 32'(oint), 32'(0));
    end
    step(1'b0, 1'b0);
    chk("ipg_off", 32'(ipg), 32'(0));
    chk("oint_on", 32'(oint), 32'(1));
    for (int t = 0; t < nth; t++) begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("oint_hold", 32'(oint), 32'(1));
      step(1'b0, 1'b1);
      chk("oint_th", 32'(oint), 32'(1));
      chk("itx_early", 32'(itx), 32'(0));
    end
    step(1'b0, 1'b0);
    chk("oint_plus1", 32'(oint), 32'(1));
    chk("itx_early2", 32'(itx), 32'(0));
    step(1'b0, 1'b0);
    chk("oint_off", 32'(oint), 32'(0));
    chk("itx_on", 32'(itx), 32'(1));
    step(1'b0, 1'b1);
    chk("itx_on2", 32'(itx), 32'(1));
    chk("ovr_tx_th", 32'(ovr), 32'(0));
    step(1'b0, 1'b0);
    chk("itx_off", 32'(itx), 32'(0));
    chk("read_busy", 32'(busy), 32'(1));
    chk("arow_first", 32'(arow), 32'(0));
    chk("rstrt_wait", 32'(rstrt), 32'(0));
  endtask

  // One row: th, then 2 rstrt / 3 ldshft / 8 enrd cycles; optional injected events or abort.
  task automatic run_row(input int r, input bit last, input int th_at, input int tv_at,
                         input int abort_at);
    step(1'b0, 1'b1);
    chk("row_th_lag", 32'(rstrt), 32'(0));
    chk("arow_wait", 32'(arow), 32'(r));
    for (int i = 0; i < 13; i++) begin
      if (i == abort_at) begin
        en = 1'b0;
        step(1'b0, 1'b0);
        chk("abort_ldshft", 32'(ldshft), 32'(0));
        chk("abort_arow", 32'(arow), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        en = 1'b1;
        return;
      end
      step(1'(i == tv_at), 1'(i == th_at));
      chk("rstrt", 32'(rstrt), 32'(i < 2));
      chk("ldshft", 32'(ldshft), 32'(i >= 2 && i < 5));
      chk("enrd", 32'(enrd), 32'(i >= 5));
      chk("arow", 32'(arow), 32'(r));
      chk("ovr", 32'(ovr), 32'(i == th_at || i == tv_at));
      chk("row_busy", 32'(busy), 32'(1));
    end
    step(1'b0, 1'b0);
    chk("row_end_enrd", 32'(enrd), 32'(0));
    chk("row_end_arow", 32'(arow), last ? 32'(0) : 32'(r + 1));
    chk("row_end_busy", 32'(busy), last ? 32'(0) : 32'(1));
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("reset_all", all_out(), 32'(0));
    init_n = 1'b1;
    en     = 1'b1;
    step(1'b0, 1'b1);
    chk("idle_th_busy", 32'(busy), 32'(0));
    chk("idle_th_ovr", 32'(ovr), 32'(0));

    // Normal frame, iexp=3.
    frame_head(11'd3, 11'd3, 3, 1'b0);
    for (int r = 0; r < 4; r++) run_row(r, r == 3, -1, -1, -1);
    step(1'b0, 1'b0);
    chk("post_frame_idle", all_out(), 32'(0));

    // iexp=0 behaves as 1; tv+th together in idle; tv and th overruns during readout.
    frame_head(11'd0, 11'd0, 1, 1'b1);
    run_row(0, 1'b0, -1, 7, -1);
    run_row(1, 1'b0, 8, -1, -1);
    run_row(2, 1'b0, -1, -1, -1);
    run_row(3, 1'b1, -1, -1, -1);

    // iexp latched at PG entry, changed afterwards; abort during row 2 ldshft.
    frame_head(11'd2, 11'd5, 2, 1'b0);
    run_row(0, 1'b0, -1, -1, -1);
    run_row(1, 1'b0, -1, -1, -1);
    run_row(2, 1'b0, -1, -1, 3);
    step(1'b0, 1'b1);
    chk("after_abort", all_out(), 32'(0));
    frame_head(11'd1, 11'd1, 1, 1'b0);
    for (int r = 0; r < 4; r++) run_row(r, r == 3, -1, -1, -1);

    // Reset mid-integration; sequencer must wait for a new tv.
    iexp = 11'd3;
    step(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
    chk("pre_rst_oint", 32'(oint), 32'(1));
    init_n = 1'b0;
    step(1'b0, 1'b1);
    chk("rst_all", all_out(), 32'(0));
    init_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1);
      chk("rst_stay_idle", all_out(), 32'(0));
    end
    frame_head(11'd1, 11'd1, 1, 1'b0);
    for (int r = 0; r < 4; r++) run_row(r, r == 3, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
